// File: rtl/turn_stalk_conditioner.sv
// Turn-stalk input conditioner: synchronises, debounces and arbitrates the raw
// left/right/hazard contacts into clean requests. Define HAZARD_LATCH_EN for push-button hazard.
module turn_stalk_conditioner #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_W           = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic left_raw,
    input  logic right_raw,
    input  logic hazard_raw,
    output logic left,
    output logic right,
    output logic hazard_active,
    output logic fault
);

    localparam int IDX_L = 0;
    localparam int IDX_R = 1;
    localparam int IDX_H = 2;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_LEFT     = 3'd1,
        ST_RIGHT    = 3'd2,
        ST_HAZARD   = 3'd3,
        ST_CONFLICT = 3'd4
    } state_t;

    logic [2:0]                        w_raw;
    logic [2:0]                        w_sync;
    logic [2:0][SYNC_STAGES-1:0]       r_sync;
    logic [2:0][CNT_W-1:0]             r_cnt;
    logic [2:0]                        r_db;
    logic                              w_hazard_req;
    state_t                            r_state;
    state_t                            w_next;

    assign w_raw = {hazard_raw, right_raw, left_raw};

    genvar g;
    generate
        for (g = 0; g < 3; g++) begin : g_sync_tap
            assign w_sync[g] = r_sync[g][SYNC_STAGES-1];
        end
    endgenerate

    // Any sample matching the debounced value restarts the count from zero.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync <= '0;
            r_cnt  <= '0;
            r_db   <= '0;
        end else begin
            for (int i = 0; i < 3; i++) begin
                r_sync[i] <= {r_sync[i][SYNC_STAGES-2:0], w_raw[i]};
                if (w_sync[i] == r_db[i]) begin
                    r_cnt[i] <= '0;
                end else if (r_cnt[i] == CNT_LAST) begin
                    r_db[i]  <= w_sync[i];
                    r_cnt[i] <= '0;
                end else begin
                    r_cnt[i] <= r_cnt[i] + 1'b1;
                end
            end
        end
    end

`ifdef HAZARD_LATCH_EN
    logic r_hazard_mode;
    logic w_h_rise;

    // Toggle on the same edge the debounced hazard rises, so latency matches level mode.
    assign w_h_rise = !r_db[IDX_H] && w_sync[IDX_H] && (r_cnt[IDX_H] == CNT_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_hazard_mode <= 1'b0;
        end else if (w_h_rise) begin
            r_hazard_mode <= ~r_hazard_mode;
        end
    end

    assign w_hazard_req = r_hazard_mode;
`else
    assign w_hazard_req = r_db[IDX_H];
`endif

    // A direct reversal passes through IDLE so the controller restarts from all-off.
    always_comb begin
        w_next = ST_IDLE;
        if (w_hazard_req) begin
            w_next = ST_HAZARD;
        end else if (r_db[IDX_L] && r_db[IDX_R]) begin
            w_next = ST_CONFLICT;
        end else if (r_db[IDX_L]) begin
            w_next = (r_state == ST_RIGHT) ? ST_IDLE : ST_LEFT;
        end else if (r_db[IDX_R]) begin
            w_next = (r_state == ST_LEFT) ? ST_IDLE : ST_RIGHT;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= ST_IDLE;
            left          <= 1'b0;
            right         <= 1'b0;
            hazard_active <= 1'b0;
            fault         <= 1'b0;
        end else begin
            r_state       <= w_next;
            left          <= (w_next == ST_LEFT)  || (w_next == ST_HAZARD);
            right         <= (w_next == ST_RIGHT) || (w_next == ST_HAZARD);
            hazard_active <= (w_next == ST_HAZARD);
            fault         <= (w_next == ST_CONFLICT);
        end
    end

endmodule

// File: tb/tb_turn_stalk_conditioner.sv
// Bench for turn_stalk_conditioner: directed scenarios plus randomized contact
// activity, all checked against a behavioural model of the conditioner.
module tb_turn_stalk_conditioner;

    localparam int S = 2;
    localparam int D = 4;

    logic clk = 1'b0;
    logic reset, left_raw, right_raw, hazard_raw;
    logic left, right, hazard_active, fault;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    turn_stalk_conditioner #(
        .SYNC_STAGES(S), .DEBOUNCE_CYCLES(D), .CNT_W(8)
    ) dut (
        .clk(clk), .reset(reset),
        .left_raw(left_raw), .right_raw(right_raw), .hazard_raw(hazard_raw),
        .left(left), .right(right), .hazard_active(hazard_active), .fault(fault)
    );

    // Behavioural model: raw samples age through a queue, a debounced value
    // flips after D consecutive disagreeing samples, then priority arbitration.
    typedef enum int {M_IDLE, M_LEFT, M_RIGHT, M_HAZ, M_CONF} mst_t;
    bit   m_q[3][$];
    bit   m_db[3];
    int   m_run[3];
    bit   m_mode;
    mst_t m_st;

    function automatic void model_clear();
        for (int i = 0; i < 3; i++) begin
            m_q[i].delete();
            for (int j = 0; j < S; j++) m_q[i].push_back(1'b0);
            m_db[i]  = 1'b0;
            m_run[i] = 0;
        end
        m_mode = 1'b0;
        m_st   = M_IDLE;
    endfunction

    function automatic void model_edge(input bit rst, input bit l, input bit r, input bit h);
        bit hz;
        bit raw[3];
        mst_t prev;
        if (rst) begin
            model_clear();
            return;
        end
        raw[0] = l; raw[1] = r; raw[2] = h;
`ifdef HAZARD_LATCH_EN
        hz = m_mode;
`else
        hz = m_db[2];
`endif
        prev = m_st;
        if (hz)                       m_st = M_HAZ;
        else if (m_db[0] && m_db[1])  m_st = M_CONF;
        else if (m_db[0])             m_st = (prev == M_RIGHT) ? M_IDLE : M_LEFT;
        else if (m_db[1])             m_st = (prev == M_LEFT)  ? M_IDLE : M_RIGHT;
        else                          m_st = M_IDLE;
        for (int i = 0; i < 3; i++) begin
            bit s;
            s = m_q[i][0];
            if (s != m_db[i]) begin
                m_run[i]++;
                if (m_run[i] == D) begin
                    if (i == 2 && s) m_mode = ~m_mode;
                    m_db[i]  = s;
                    m_run[i] = 0;
                end
            end else begin
                m_run[i] = 0;
            end
            void'(m_q[i].pop_front());
            m_q[i].push_back(raw[i]);
        end
    endfunction

    function automatic logic [3:0] model_out();
        logic [3:0] o;
        o[3] = (m_st == M_LEFT)  || (m_st == M_HAZ);
        o[2] = (m_st == M_RIGHT) || (m_st == M_HAZ);
        o[1] = (m_st == M_HAZ);
        o[0] = (m_st == M_CONF);
        return o;
    endfunction

    task automatic tick(input bit rst, input bit l, input bit r, input bit h);
        logic [3:0] exp_o;
        reset = rst; left_raw = l; right_raw = r; hazard_raw = h;
        @(posedge clk);
        model_edge(rst, l, r, h);
        #1;
        exp_o = model_out();
        total++;
        if ({left, right, hazard_active, fault} !== exp_o) begin
            bad++;
            $display("FAIL model_cmp t=%0t got(l,r,h,f)=%b exp=%b", $time,
                     {left, right, hazard_active, fault}, exp_o);
        end
    endtask

    task automatic do_reset();
        tick(1, 0, 0, 0);
        tick(1, 0, 0, 0);
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            tick(1, 1, 1, 1);
            total++;
            if ({left, right, hazard_active, fault} !== 4'b0000) begin
                bad++;
                $display("FAIL reset_hold cyc=%0d got=%b exp=0000", i, {left, right, hazard_active, fault});
            end
        end
        for (int i = 0; i < 8; i++) begin
            tick(0, 1, 1, 1);
            total++;
            if (left !== (i >= 6) || right !== (i >= 6) || hazard_active !== (i >= 6)) begin
                bad++;
                $display("FAIL reset_release edge=%0d got(l,r,h)=%b%b%b exp=%0d", i, left, right, hazard_active, i >= 6);
            end
        end
    endtask

    task automatic test_clean_left();
        do_reset();
        for (int i = 0; i < 10; i++) begin
            tick(0, 1, 0, 0);
            total++;
            if (left !== (i >= 6) || right !== 1'b0 || hazard_active !== 1'b0 || fault !== 1'b0) begin
                bad++;
                $display("FAIL clean_left edge=%0d got(l,r,h,f)=%b%b%b%b exp_left=%0d", i, left, right, hazard_active, fault, i >= 6);
            end
        end
    endtask

    task automatic test_bounce();
        bit pat[4] = '{1, 0, 1, 0};
        do_reset();
        for (int i = 0; i < 14; i++) begin
            tick(0, (i < 4) ? pat[i] : 1'b1, 0, 0);
            total++;
            if (left !== (i >= 10)) begin
                bad++;
                $display("FAIL bounce edge=%0d got=%b exp=%0d", i, left, i >= 10);
            end
        end
    endtask

    task automatic test_reset_abort();
        do_reset();
        for (int i = 0; i < 4; i++) tick(0, 1, 0, 0);
        tick(1, 1, 0, 0);
        for (int i = 0; i < 8; i++) begin
            tick(0, 1, 0, 0);
            total++;
            if (left !== (i >= 6)) begin
                bad++;
                $display("FAIL reset_abort edge=%0d got=%b exp=%0d", i, left, i >= 6);
            end
        end
    endtask

    task automatic test_reversal();
        do_reset();
        for (int i = 0; i < 10; i++) tick(0, 1, 0, 0);
        for (int i = 0; i < 10; i++) begin
            tick(0, 0, 1, 0);
            total++;
            if (left !== (i < 6) || right !== (i >= 7)) begin
                bad++;
                $display("FAIL reversal edge=%0d got(l,r)=%b%b exp=%0d%0d", i, left, right, i < 6, i >= 7);
            end
        end
    endtask

    task automatic test_conflict_hazard();
        do_reset();
        for (int i = 0; i < 10; i++) begin
            tick(0, 1, 1, 0);
            total++;
            if (fault !== (i >= 6) || left !== 1'b0 || right !== 1'b0) begin
                bad++;
                $display("FAIL conflict edge=%0d got(l,r,f)=%b%b%b exp_f=%0d", i, left, right, fault, i >= 6);
            end
        end
        for (int i = 0; i < 10; i++) begin
            tick(0, 1, 1, 1);
            total++;
            if (hazard_active !== (i >= 6) || left !== (i >= 6) || right !== (i >= 6) || fault !== (i < 6)) begin
                bad++;
                $display("FAIL hazard_wins edge=%0d got(l,r,h,f)=%b%b%b%b", i, left, right, hazard_active, fault);
            end
        end
    endtask

`ifdef HAZARD_LATCH_EN
    task automatic test_hazard_latch();
        do_reset();
        for (int i = 0; i < 8; i++) tick(0, 0, 0, 1);
        for (int i = 0; i < 20; i++) begin
            tick(0, 0, 0, 0);
            total++;
            if (hazard_active !== 1'b1) begin
                bad++;
                $display("FAIL latch_on edge=%0d got=%b exp=1", i, hazard_active);
            end
        end
        for (int i = 0; i < 8; i++) tick(0, 0, 0, 1);
        for (int i = 0; i < 20; i++) begin
            tick(0, 0, 0, 0);
            total++;
            if (i >= 10 && hazard_active !== 1'b0) begin
                bad++;
                $display("FAIL latch_off edge=%0d got=%b exp=0", i, hazard_active);
            end
        end
    endtask
`endif

    task automatic test_random();
        bit l, r, h;
        do_reset();
        l = 0; r = 0; h = 0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 9) == 0) l = ~l;
            if ($urandom_range(0, 9) == 0) r = ~r;
            if ($urandom_range(0, 24) == 0) h = ~h;
            tick($urandom_range(0, 399) == 0, l, r, h);
        end
    endtask

    initial begin
        model_clear();
        reset = 1'b1; left_raw = 1'b0; right_raw = 1'b0; hazard_raw = 1'b0;
        test_reset();
        test_clean_left();
        test_bounce();
        test_reset_abort();
        test_reversal();
        test_conflict_hazard();
`ifdef HAZARD_LATCH_EN
        test_hazard_latch();
`endif
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
